// File: rtl/stack_sequencer_if.sv
// ---------------------------------------------------------------------------
// stack_sequencer_if
//
// Purpose: groups every non-clock/reset signal of the stack sequencer into one
// bundle. The "master" modport is the sequencer's view, and the "slave"
// modport is the view of its environment (request source, SP register and
// data memory).
//
// Handshake: PUSH, POP and LD_REQ are level requests that act as "valid".
// The sequencer is "ready" exactly when BUSY is low. A request is taken only
// in a cycle where BUSY is low, and it is taken on the rising edge that ends
// that cycle. While BUSY is high, requests are ignored and are not queued.
// DONE, ERR_OVF and ERR_UNF report the outcome with a one-cycle pulse.
//
// Signals:
//   PUSH, POP, LD_REQ      request strobes (level, IDLE-sampled)
//   LD_VAL  [AW]           new SP value for a load
//   DIN     [WIDTH]        data to push
//   SP      [AW]           current SP register output
//   MEM_RDATA [WIDTH]      memory read data, one cycle after MEM_RE
//   SP_INC/SP_DECR/SP_LD   SP register control strobes
//   SP_DIN  [AW]           SP register load value
//   MEM_ADDR [AW], MEM_WE, MEM_RE, MEM_WDATA [WIDTH]   memory port
//   DOUT    [WIDTH]        last popped data
//   BUSY, DONE, ERR_OVF, ERR_UNF  status
// ---------------------------------------------------------------------------
interface stack_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
);
  logic             PUSH;
  logic             POP;
  logic             LD_REQ;
  logic [AW-1:0]    LD_VAL;
  logic [WIDTH-1:0] DIN;
  logic [AW-1:0]    SP;
  logic [WIDTH-1:0] MEM_RDATA;
  logic             SP_INC;
  logic             SP_DECR;
  logic             SP_LD;
  logic [AW-1:0]    SP_DIN;
  logic [AW-1:0]    MEM_ADDR;
  logic             MEM_WE;
  logic             MEM_RE;
  logic [WIDTH-1:0] MEM_WDATA;
  logic [WIDTH-1:0] DOUT;
  logic             BUSY;
  logic             DONE;
  logic             ERR_OVF;
  logic             ERR_UNF;

  modport master (
    input  PUSH, POP, LD_REQ, LD_VAL, DIN, SP, MEM_RDATA,
    output SP_INC, SP_DECR, SP_LD, SP_DIN, MEM_ADDR, MEM_WE, MEM_RE,
           MEM_WDATA, DOUT, BUSY, DONE, ERR_OVF, ERR_UNF
  );

  modport slave (
    output PUSH, POP, LD_REQ, LD_VAL, DIN, SP, MEM_RDATA,
    input  SP_INC, SP_DECR, SP_LD, SP_DIN, MEM_ADDR, MEM_WE, MEM_RE,
           MEM_WDATA, DOUT, BUSY, DONE, ERR_OVF, ERR_UNF
  );
endinterface

// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//
// Purpose: multi-cycle push / pop / load sequencer for a stack. It drives the
// INC/DECR/LD strobes of an external SP register, reads that register's
// output back, and addresses a synchronous-read data memory. It also tracks
// occupancy so that a push to a full stack or a pop from an empty stack is
// rejected with an error pulse.
//
// Ports:
//   CLK          rising-edge clock
//   RST          synchronous, active-high reset (shared with the SP register)
//   bus          stack_sequencer_if.master, with requests, SP/memory port and status
//   dbg_state_o  current FSM state encoding, for debug and checkers
//
// Stack discipline: the stack grows downward. A push pre-decrements SP and
// then writes to the new SP. A pop reads at SP and then post-increments.
// ---------------------------------------------------------------------------
module stack_sequencer #(
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  stack_sequencer_if.master      bus,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PUSH_DEC = 3'd2,
    S_PUSH_WR  = 3'd3,
    S_POP_RD   = 3'd4,
    S_POP_CAP  = 3'd5
  } state_e;

  // Occupancy is one bit wider than SP so that "full" (2^AW entries) and
  // "empty" (0) are distinct values.
  localparam logic [AW:0] CNT_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [AW-1:0]    ld_q,    ld_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             done_q,  done_d;
  logic             ovf_q,   ovf_d;
  logic             unf_q,   unf_d;

  logic full_w;
  logic empty_w;

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      count_q <= '0;
      data_q  <= '0;
      ld_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. The status pulses default to 0, so each pulse lasts
  // exactly one cycle: the first IDLE cycle after the operation or rejection.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    data_d  = data_q;
    ld_d    = ld_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Fixed priority LD_REQ > PUSH > POP. Losing requests are dropped.
        if (bus.LD_REQ) begin
          ld_d    = bus.LD_VAL;
          state_d = S_LOAD;
        end else if (bus.PUSH) begin
          if (full_w) begin
            ovf_d = 1'b1;
          end else begin
            data_d  = bus.DIN;
            state_d = S_PUSH_DEC;
          end
        end else if (bus.POP) begin
          if (empty_w) begin
            unf_d = 1'b1;
          end else begin
            state_d = S_POP_RD;
          end
        end
      end

      S_LOAD: begin
        // A new SP means the old contents are no longer reachable.
        count_d = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_PUSH_DEC: begin
        state_d = S_PUSH_WR;
      end

      S_PUSH_WR: begin
        count_d = count_q + CNT_ONE;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_POP_RD: begin
        state_d = S_POP_CAP;
      end

      S_POP_CAP: begin
        // The read issued in POP_RD returns data during this cycle.
        dout_d  = bus.MEM_RDATA;
        count_d = count_q - CNT_ONE;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Moore output decode. Each strobe belongs to exactly one state, so the
  // SP strobes are mutually exclusive and MEM_WE/MEM_RE are never both high.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.SP_INC    = 1'b0;
    bus.SP_DECR   = 1'b0;
    bus.SP_LD     = 1'b0;
    bus.SP_DIN    = '0;
    bus.MEM_ADDR  = '0;
    bus.MEM_WE    = 1'b0;
    bus.MEM_RE    = 1'b0;
    bus.MEM_WDATA = '0;

    case (state_q)
      S_LOAD: begin
        bus.SP_LD  = 1'b1;
        bus.SP_DIN = ld_q;
      end
      S_PUSH_DEC: begin
        bus.SP_DECR = 1'b1;
      end
      S_PUSH_WR: begin
        // SP was already decremented in PUSH_DEC.
        bus.MEM_ADDR  = bus.SP;
        bus.MEM_WE    = 1'b1;
        bus.MEM_WDATA = data_q;
      end
      S_POP_RD: begin
        bus.MEM_ADDR = bus.SP;
        bus.MEM_RE   = 1'b1;
      end
      S_POP_CAP: begin
        bus.SP_INC = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.DOUT    = dout_q;
  assign bus.BUSY    = (state_q != S_IDLE);
  assign bus.DONE    = done_q;
  assign bus.ERR_OVF = ovf_q;
  assign bus.ERR_UNF = unf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;
  localparam int W    = 8;
  localparam int AW   = 8;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  stack_sequencer_if #(.WIDTH(W), .AW(AW)) bus ();
  logic [2:0] dbg_state;

  stack_sequencer #(.WIDTH(W), .AW(AW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- environment: SP register and memory ----------------
  logic [W-1:0] mem [DEPTH];

  always @(posedge CLK) begin
    if (RST)              bus.SP <= '0;
    else if (bus.SP_LD)   bus.SP <= bus.SP_DIN;
    else if (bus.SP_INC)  bus.SP <= bus.SP + 8'd1;
    else if (bus.SP_DECR) bus.SP <= bus.SP - 8'd1;
  end

  always @(posedge CLK) begin
    if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
    if (bus.MEM_RE) bus.MEM_RDATA <= mem[bus.MEM_ADDR];
  end

  // ---------------- behavioural model ----------------
  // One record per clock cycle with the outputs that the cycle must show.
  typedef struct packed {
    logic          busy;
    logic          sp_inc;
    logic          sp_decr;
    logic          sp_ld;
    logic [AW-1:0] sp_din;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  dout;
    logic          done;
    logic          ovf;
    logic          unf;
    logic [AW-1:0] sp;
  } cyc_t;

  cyc_t         exp_q[$];
  logic [W-1:0] stk[$];
  logic [AW-1:0] sp_m   = '0;
  logic [W-1:0]  dout_m = '0;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  function automatic cyc_t idle_rec();
    cyc_t r;
    r      = '0;
    r.sp   = sp_m;
    r.dout = dout_m;
    return r;
  endfunction

  // Expand one request (made in the current cycle c0) into the expected
  // cycles c0, c1, ... from the operation timeline.
  function automatic void gen_op(input logic ld, input logic push, input logic pop,
                                 input logic [W-1:0] d, input logic [AW-1:0] lv);
    cyc_t r;
    if (exp_q.size() == 0) exp_q.push_back(idle_rec());
    if (ld) begin
      r = idle_rec(); r.busy = 1; r.sp_ld = 1; r.sp_din = lv; exp_q.push_back(r);
      sp_m = lv;
      stk.delete();
      r = idle_rec(); r.done = 1; exp_q.push_back(r);
    end else if (push) begin
      if (stk.size() == DEPTH) begin
        r = idle_rec(); r.ovf = 1; exp_q.push_back(r);
      end else begin
        r = idle_rec(); r.busy = 1; r.sp_decr = 1; exp_q.push_back(r);
        sp_m = sp_m - 8'd1;
        r = idle_rec(); r.busy = 1; r.mem_we = 1; r.mem_addr = sp_m; r.mem_wdata = d;
        exp_q.push_back(r);
        stk.push_back(d);
        r = idle_rec(); r.done = 1; exp_q.push_back(r);
      end
    end else if (pop) begin
      if (stk.size() == 0) begin
        r = idle_rec(); r.unf = 1; exp_q.push_back(r);
      end else begin
        r = idle_rec(); r.busy = 1; r.mem_re = 1; r.mem_addr = sp_m; exp_q.push_back(r);
        r = idle_rec(); r.busy = 1; r.sp_inc = 1; exp_q.push_back(r);
        dout_m = stk.pop_back();
        sp_m   = sp_m + 8'd1;
        r = idle_rec(); r.done = 1; exp_q.push_back(r);
      end
    end
  endfunction

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge CLK) begin
    if (chk_en) begin
      cyc_t e, a;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : idle_rec();
      a.busy      = bus.BUSY;
      a.sp_inc    = bus.SP_INC;
      a.sp_decr   = bus.SP_DECR;
      a.sp_ld     = bus.SP_LD;
      a.sp_din    = bus.SP_DIN;
      a.mem_addr  = bus.MEM_ADDR;
      a.mem_we    = bus.MEM_WE;
      a.mem_re    = bus.MEM_RE;
      a.mem_wdata = bus.MEM_WDATA;
      a.dout      = bus.DOUT;
      a.done      = bus.DONE;
      a.ovf       = bus.ERR_OVF;
      a.unf       = bus.ERR_UNF;
      a.sp        = bus.SP;
      n_checks++;
      if (a !== e)
        $display("FAIL cycle_cmp t=%0t actual=%h expected=%h (busy,inc,dec,ld,sp_din,addr,we,re,wdata,dout,done,ovf,unf,sp)",
                 $time, a, e);
      else
        n_pass++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    $display("FAIL %s timeout actual=pending expected=drained", name);
  endtask

  // Wait until only the current cycle's record is pending.
  task automatic wait_room();
    int n = 0;
    while (exp_q.size() > 1 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (exp_q.size() > 1) bound_fail("wait_room");
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge CLK); #1; n++;
    end
    if (exp_q.size() != 0) bound_fail("drain");
  endtask

  task automatic issue(input logic ld, input logic push, input logic pop,
                       input logic [W-1:0] d, input logic [AW-1:0] lv);
    wait_room();
    bus.LD_REQ = ld; bus.PUSH = push; bus.POP = pop; bus.DIN = d; bus.LD_VAL = lv;
    gen_op(ld, push, pop, d, lv);
    @(posedge CLK); #1;
    bus.LD_REQ = 0; bus.PUSH = 0; bus.POP = 0;
  endtask

  // Push, then reset while the sequencer is in PUSH_DEC.
  task automatic rst_during_push(input logic [W-1:0] d);
    cyc_t r;
    wait_room();
    bus.PUSH = 1; bus.DIN = d;
    if (exp_q.size() == 0) exp_q.push_back(idle_rec());
    r = idle_rec(); r.busy = 1; r.sp_decr = 1; exp_q.push_back(r);
    @(posedge CLK); #1;
    bus.PUSH = 0;
    RST = 1;
    sp_m = '0; dout_m = '0; stk.delete();
    exp_q.push_back(idle_rec());
    @(posedge CLK); #1;
    RST = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.PUSH = 0; bus.POP = 0; bus.LD_REQ = 0; bus.LD_VAL = '0; bus.DIN = '0;
    RST = 1;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    chk_en = 1;
    @(posedge CLK); #1;

    // Push 0xA5 from SP=0, then pop it back.
    issue(0, 1, 0, 8'hA5, 8'h00);
    drain();
    chk("sp_after_push", 32'(bus.SP), 32'h0000_00FF);
    issue(0, 0, 1, 8'h00, 8'h00);
    drain();
    chk("dout_after_pop", 32'(bus.DOUT), 32'h0000_00A5);
    chk("sp_after_pop", 32'(bus.SP), 32'h0000_0000);

    // Pop when empty.
    issue(0, 0, 1, 8'h00, 8'h00);
    drain();
    chk("sp_after_underflow", 32'(bus.SP), 32'h0000_0000);

    // All three requests at once: load wins.
    issue(1, 1, 1, 8'h77, 8'h40);
    drain();
    chk("sp_after_load", 32'(bus.SP), 32'h0000_0040);
    issue(0, 0, 1, 8'h00, 8'h00);

    // Fill the stack completely, overflow once, then empty it.
    for (int i = 0; i < DEPTH; i++) issue(0, 1, 0, W'(i + 1), 8'h00);
    issue(0, 1, 0, 8'hEE, 8'h00);
    drain();
    chk("sp_when_full", 32'(bus.SP), 32'h0000_0040);
    for (int i = 0; i < DEPTH; i++) issue(0, 0, 1, 8'h00, 8'h00);
    drain();
    chk("dout_last_of_drain", 32'(bus.DOUT), 32'h0000_0001);
    chk("sp_after_drain", 32'(bus.SP), 32'h0000_0040);

    // Reset during PUSH_DEC.
    issue(0, 1, 0, 8'h3C, 8'h00);
    rst_during_push(8'h5A);
    drain();
    chk("dout_after_rst", 32'(bus.DOUT), 32'h0000_0000);
    chk("sp_after_rst", 32'(bus.SP), 32'h0000_0000);
    issue(0, 0, 1, 8'h00, 8'h00);

    // Randomized mixed traffic.
    for (int k = 0; k < 300; k++) begin
      logic ld, pu, po;
      ld = ($urandom_range(0, 15) == 0);
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) issue(0, 0, 0, 8'h00, 8'h00);
      issue(ld, pu, po, W'($urandom), AW'($urandom));
    end
    drain();
    repeat (2) @(posedge CLK);
    #1;
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end
endmodule
